// File: rtl/mcpu5_pkg.sv
// Shared opcodes, widths and sequencer state encoding for the MCPU5plus host sequencer.
package mcpu5_pkg;

  localparam int unsigned BUS_W  = 8;
  localparam int unsigned INST_W = 6;
  localparam int unsigned STEP_W = 16;

  localparam logic [INST_W-1:0] OP_OUT = 6'b111011;
  localparam logic [2:0]        OP_STA = 3'b101;
  localparam logic [1:0]        OP_LDI = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_LO,
    ST_OUTW,
    ST_HI,
    ST_FETCH,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mcpu5_prog_ram.sv
// Program RAM: 2**AW x INST_W words, synchronous write, registered read.
// The read register doubles as the core's instruction pin driver, hence its reset.
module mcpu5_prog_ram
  import mcpu5_pkg::*;
#(
  parameter int unsigned AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [INST_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [INST_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [INST_W-1:0] r_mem [DEPTH];
  logic [INST_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mcpu5_host_seq.sv
// Host sequencer for the MCPU5plus core: strobes core clk/rst, serves instructions, streams OUT values.
// Define MCPU5_HOST_BREAKPOINT_EN to add the bp_en/bp_addr breakpoint ports.
module mcpu5_host_seq
  import mcpu5_pkg::*;
#(
  parameter int unsigned AW         = 8,
  parameter int unsigned SETTLE     = 2,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_prog_we,
  input  logic [AW-1:0]     i_prog_addr,
  input  logic [INST_W-1:0] i_prog_data,
  input  logic              i_start,
  input  logic              i_halt_req,
  input  logic [STEP_W-1:0] i_max_steps,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_cpu_clk,
  output logic              o_cpu_rst,
  output logic [INST_W-1:0] o_cpu_inst,
  input  logic [BUS_W-1:0]  i_cpu_bus,
  output logic              o_out_valid,
  output logic [BUS_W-1:0]  o_out_data,
  input  logic              i_out_ready,
  output logic [BUS_W-1:0]  o_pc_q,
  output logic [BUS_W-1:0]  o_accu_q,
  output logic [STEP_W-1:0] o_step_cnt
`ifdef MCPU5_HOST_BREAKPOINT_EN
  ,
  input  logic              i_bp_en,
  input  logic [BUS_W-1:0]  i_bp_addr
`endif
);

  localparam int unsigned CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam int unsigned RCW   = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);

  state_e              r_state, w_state_d;
  logic [CNT_W-1:0]    r_cnt, w_cnt_d;
  logic [RCW-1:0]      r_rcnt, w_rcnt_d;
  logic                r_cpu_clk, w_cpu_clk_d;
  logic                r_cpu_rst, w_cpu_rst_d;
  logic                r_out_valid, w_out_valid_d;
  logic [BUS_W-1:0]    r_out_data, w_out_data_d;
  logic [BUS_W-1:0]    r_pc_q, w_pc_d;
  logic [BUS_W-1:0]    r_accu_q, w_accu_d;
  logic [STEP_W-1:0]   r_step_cnt, w_step_d;
  logic                r_busy, w_busy_d;
  logic                r_done, w_done_d;

  logic                w_settled;
  logic                w_bp;
  logic                w_stop;
  logic                w_we;
  logic                w_rd_en;
  logic [AW-1:0]       w_rd_addr;
  logic [INST_W-1:0]   w_rd_data;

  assign w_settled = (r_cnt == CNT_W'(SETTLE));
  assign w_we      = i_prog_we & ((r_state == ST_IDLE) | (r_state == ST_DONE));

`ifdef MCPU5_HOST_BREAKPOINT_EN
  assign w_bp = i_bp_en & (r_pc_q == i_bp_addr);
`else
  assign w_bp = 1'b0;
`endif

  assign w_stop = i_halt_req
                | ((i_max_steps != '0) & (r_step_cnt == i_max_steps))
                | w_bp;

  mcpu5_prog_ram #(
    .AW (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (i_prog_addr),
    .i_wdata (i_prog_data),
    .i_re    (w_rd_en),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rcnt      <= '0;
      r_cpu_clk   <= 1'b0;
      r_cpu_rst   <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_pc_q      <= '0;
      r_accu_q    <= '0;
      r_step_cnt  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_rcnt      <= w_rcnt_d;
      r_cpu_clk   <= w_cpu_clk_d;
      r_cpu_rst   <= w_cpu_rst_d;
      r_out_valid <= w_out_valid_d;
      r_out_data  <= w_out_data_d;
      r_pc_q      <= w_pc_d;
      r_accu_q    <= w_accu_d;
      r_step_cnt  <= w_step_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_rcnt_d      = r_rcnt;
    w_cpu_clk_d   = r_cpu_clk;
    w_cpu_rst_d   = r_cpu_rst;
    w_out_valid_d = r_out_valid;
    w_out_data_d  = r_out_data;
    w_pc_d        = r_pc_q;
    w_accu_d      = r_accu_q;
    w_step_d      = r_step_cnt;
    w_rd_en       = 1'b0;
    w_rd_addr     = '0;

    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_state_d   = ST_RST;
          w_cnt_d     = '0;
          w_rcnt_d    = '0;
          w_cpu_clk_d = 1'b1;
          w_cpu_rst_d = 1'b1;
        end
      end
      ST_RST: begin
        if (!w_settled) begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end else begin
          w_cnt_d = '0;
          if (r_cpu_clk) begin
            w_cpu_clk_d = 1'b0;
          end else if (r_rcnt == RCW'(RST_CYCLES - 1)) begin
            w_state_d   = ST_LO;
            w_cpu_rst_d = 1'b0;
            w_pc_d      = '0;
            w_step_d    = '0;
            w_rd_en     = 1'b1;
          end else begin
            w_rcnt_d    = r_rcnt + RCW'(1);
            w_cpu_clk_d = 1'b1;
          end
        end
      end
      ST_LO: begin
        if (!w_settled) begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end else begin
          w_cnt_d  = '0;
          w_accu_d = i_cpu_bus;
          if (w_rd_data == OP_OUT) begin
            w_state_d     = ST_OUTW;
            w_out_valid_d = 1'b1;
            w_out_data_d  = i_cpu_bus;
          end else begin
            w_state_d   = ST_HI;
            w_cpu_clk_d = 1'b1;
          end
        end
      end
      ST_OUTW: begin
        if (i_out_ready) begin
          w_state_d     = ST_HI;
          w_out_valid_d = 1'b0;
          w_cpu_clk_d   = 1'b1;
        end
      end
      ST_HI: begin
        if (!w_settled) begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end else begin
          // Fetch straight from the settled bus so the new word lands while cpu_clk is still high.
          w_cnt_d   = '0;
          w_state_d = ST_FETCH;
          w_pc_d    = i_cpu_bus;
          w_step_d  = (&r_step_cnt) ? r_step_cnt : r_step_cnt + STEP_W'(1);
          w_rd_en   = 1'b1;
          w_rd_addr = AW'(i_cpu_bus);
        end
      end
      ST_FETCH: begin
        w_cpu_clk_d = 1'b0;
        w_state_d   = w_stop ? ST_DONE : ST_LO;
      end
      default: begin
        w_state_d = ST_IDLE;
      end
    endcase

    w_busy_d = (w_state_d != ST_IDLE) && (w_state_d != ST_DONE);
    w_done_d = (w_state_d == ST_DONE);
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_cpu_clk   = r_cpu_clk;
  assign o_cpu_rst   = r_cpu_rst;
  assign o_cpu_inst  = w_rd_data;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_pc_q      = r_pc_q;
  assign o_accu_q    = r_accu_q;
  assign o_step_cnt  = r_step_cnt;

endmodule
